// File: rtl/stack_ctrl_pkg.sv
// Shared types and encodings for the stack controller: sequencer states,
// push/pop and byte/word operand codes, requester identifiers.
package stack_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_HI,
    S_WR_LO,
    S_RD_LO,
    S_RD_HI,
    S_CAP,
    S_RESP
  } state_t;

  localparam logic OP_PUSH  = 1'b0;
  localparam logic OP_POP   = 1'b1;
  localparam logic SZ_BYTE  = 1'b0;
  localparam logic SZ_WORD  = 1'b1;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_IRQ  = 1'b1;

endpackage

// File: rtl/stack_arb.sv
// Two-way fixed-priority arbiter (interrupt unit beats core); acks are
// combinational while enabled and the winner's ID is held for the transaction.
module stack_arb
  import stack_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic core_req,
  input  logic irq_req,
  output logic core_ack,
  output logic irq_ack,
  output logic grant,
  output logic sel_irq,
  output logic owner
);

  logic owner_q, owner_d;

  assign sel_irq  = irq_req;
  assign irq_ack  = en & irq_req;
  assign core_ack = en & core_req & ~irq_req;
  assign grant    = irq_ack | core_ack;
  assign owner    = owner_q;

  always_comb begin
    owner_d = owner_q;
    if (grant) owner_d = irq_ack ? REQ_IRQ : REQ_CORE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) owner_q <= REQ_CORE;
    else       owner_q <= owner_d;
  end

endmodule

// File: rtl/stack_ctrl.sv
// Stack pointer owner and byte-serial PUSH/POP sequencer for a byte-wide stack
// memory; bounds are checked at accept so a faulting request never touches memory.
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter logic [15:0] SP_RESET    = 16'hFF00,
  parameter logic [15:0] STACK_LIMIT = 16'hFE00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req,
  input  logic        core_pop,
  input  logic        core_word,
  input  logic [15:0] core_wdata,
  output logic        core_ack,
  output logic        core_done,
  input  logic        irq_req,
  input  logic        irq_pop,
  input  logic        irq_word,
  input  logic [15:0] irq_wdata,
  output logic        irq_ack,
  output logic        irq_done,
  output logic [15:0] rdata,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] sp_out,
  output logic        stack_empty
);

  state_t      state_q, state_d;
  logic [15:0] sp_q, sp_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic [7:0]  lo_q, lo_d;
  logic        pop_q, pop_d, word_q, word_d, err_q, err_d;

  logic        arb_en, grant, sel_irq, owner;
  logic        req_pop, req_word;
  logic [15:0] req_wdata, used;
  logic [16:0] need;
  logic        overflow, underflow;

  assign arb_en = (state_q == S_IDLE) && !reset;

  stack_arb u_arb (
    .clk      (clk),
    .reset    (reset),
    .en       (arb_en),
    .core_req (core_req),
    .irq_req  (irq_req),
    .core_ack (core_ack),
    .irq_ack  (irq_ack),
    .grant    (grant),
    .sel_irq  (sel_irq),
    .owner    (owner)
  );

  assign req_pop   = sel_irq ? irq_pop   : core_pop;
  assign req_word  = sel_irq ? irq_word  : core_word;
  assign req_wdata = sel_irq ? irq_wdata : core_wdata;

  // 17-bit compares so SP - n can never wrap past zero and look in-bounds.
  assign need      = (req_word == SZ_BYTE) ? 17'd1 : 17'd2;
  assign used      = SP_RESET - sp_q;
  assign overflow  = {1'b0, sp_q} < ({1'b0, STACK_LIMIT} + need);
  assign underflow = {1'b0, used} < need;

  assign rdata       = rdata_q;
  assign err         = err_q;
  assign sp_out      = sp_q;
  assign stack_empty = (sp_q == SP_RESET);

  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    lo_d      = lo_q;
    pop_d     = pop_q;
    word_d    = word_q;
    err_d     = err_q;
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    core_done = 1'b0;
    irq_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          pop_d   = req_pop;
          word_d  = req_word;
          wdata_d = req_wdata;
          if ((req_pop == OP_PUSH) ? overflow : underflow) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (req_pop == OP_POP) begin
            state_d = S_RD_LO;
          end else begin
            state_d = (req_word == SZ_WORD) ? S_WR_HI : S_WR_LO;
          end
        end
      end
      S_WR_HI: begin
        mem_we    = 1'b1;
        mem_addr  = sp_q - 16'd1;
        mem_wdata = wdata_q[15:8];
        sp_d      = sp_q - 16'd1;
        state_d   = S_WR_LO;
      end
      S_WR_LO: begin
        mem_we    = 1'b1;
        mem_addr  = sp_q - 16'd1;
        mem_wdata = wdata_q[7:0];
        sp_d      = sp_q - 16'd1;
        err_d     = 1'b0;
        state_d   = S_RESP;
      end
      S_RD_LO: begin
        mem_re   = 1'b1;
        mem_addr = sp_q;
        sp_d     = sp_q + 16'd1;
        state_d  = (word_q == SZ_WORD) ? S_RD_HI : S_CAP;
      end
      S_RD_HI: begin
        lo_d     = mem_rdata;
        mem_re   = 1'b1;
        mem_addr = sp_q;
        sp_d     = sp_q + 16'd1;
        state_d  = S_CAP;
      end
      S_CAP: begin
        rdata_d = (word_q == SZ_WORD) ? {mem_rdata, lo_q} : {8'h00, mem_rdata};
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_RESP: begin
        core_done = (owner == REQ_CORE);
        irq_done  = (owner == REQ_IRQ);
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sp_q    <= SP_RESET;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      lo_q    <= 8'h00;
      pop_q   <= 1'b0;
      word_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      lo_q    <= lo_d;
      pop_q   <= pop_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl: byte memory model plus a scoreboard of expected
// completions (owner, err, rdata, latency) pushed at ack and checked at done.
module tb_stack_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_pop, core_word, irq_req, irq_pop, irq_word;
  logic [15:0] core_wdata, irq_wdata;
  logic        core_ack, core_done, irq_ack, irq_done;
  logic [15:0] rdata, mem_addr, sp_out;
  logic        err, mem_we, mem_re, stack_empty;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [0:65535];

  typedef struct {
    bit          irq;
    bit          err;
    logic [15:0] rdata;
    bit          chk_rd;
    int          ack_cyc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] re_log[$];
  logic [15:0] we_log[$];
  int          nvec = 0;
  int          nfail = 0;
  int          cyc = 0;
  int          last_done_cyc = 0;
  int          last_ack_cyc = 0;

  stack_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .core_req   (core_req),
    .core_pop   (core_pop),
    .core_word  (core_word),
    .core_wdata (core_wdata),
    .core_ack   (core_ack),
    .core_done  (core_done),
    .irq_req    (irq_req),
    .irq_pop    (irq_pop),
    .irq_word   (irq_word),
    .irq_wdata  (irq_wdata),
    .irq_ack    (irq_ack),
    .irq_done   (irq_done),
    .rdata      (rdata),
    .err        (err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata),
    .sp_out     (sp_out),
    .stack_empty(stack_empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_log.push_back(mem_addr);
    end
    if (mem_re) begin
      mem_rdata <= mem[mem_addr];
      re_log.push_back(mem_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    chk("we_re_exclusive", 32'(mem_we & mem_re), 32'd0);
    if (core_done || irq_done) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", 32'({core_done, irq_done}), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("done_onehot", 32'(core_done & irq_done), 32'd0);
        chk("done_owner", 32'(irq_done), 32'(e.irq));
        chk("done_err", 32'(err), 32'(e.err));
        if (e.chk_rd) chk("done_rdata", 32'(rdata), 32'(e.rdata));
        chk("done_latency", 32'(cyc - e.ack_cyc), 32'(e.lat));
        last_done_cyc = cyc;
      end
    end
  end

  task automatic drive(input bit irq, input bit pop, input bit word, input logic [15:0] wd);
    if (irq) begin
      irq_req = 1'b1; irq_pop = pop; irq_word = word; irq_wdata = wd;
    end else begin
      core_req = 1'b1; core_pop = pop; core_word = word; core_wdata = wd;
    end
  endtask

  // Waits for this requester's ack, records the expected completion, then
  // drops the request and scrambles its operands.
  task automatic wait_ack(input bit irq, input bit e_err, input logic [15:0] e_rd,
                          input bit chk_rd, input int lat);
    exp_t e;
    int   n = 0;
    #1;
    while (!(irq ? irq_ack : core_ack) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(irq ? "ack_irq" : "ack_core", 32'(irq ? irq_ack : core_ack), 32'd1);
    chk("ack_other_low", 32'(irq ? core_ack : irq_ack), 32'd0);
    e.irq = irq; e.err = e_err; e.rdata = e_rd; e.chk_rd = chk_rd;
    e.ack_cyc = cyc; e.lat = lat;
    sb.push_back(e);
    last_ack_cyc = cyc;
    @(posedge clk);
    #1;
    if (irq) begin
      irq_req = 1'b0; irq_pop = ~irq_pop; irq_word = ~irq_word; irq_wdata = 16'hDEAD;
    end else begin
      core_req = 1'b0; core_pop = ~core_pop; core_word = ~core_word; core_wdata = 16'hBEEF;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic txn(input bit irq, input bit pop, input bit word, input logic [15:0] wd,
                     input bit e_err, input logic [15:0] e_rd, input bit chk_rd, input int lat);
    drive(irq, pop, word, wd);
    wait_ack(irq, e_err, e_rd, chk_rd, lat);
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    core_req = 1'b0; core_pop = 1'b0; core_word = 1'b0; core_wdata = 16'h0;
    irq_req  = 1'b0; irq_pop  = 1'b0; irq_word  = 1'b0; irq_wdata  = 16'h0;
    repeat (2) @(negedge clk);
    chk("reset_strobes", 32'({core_ack, irq_ack, core_done, irq_done, err, mem_we, mem_re}), 32'd0);
    chk("reset_rdata", 32'(rdata), 32'd0);
    chk("reset_mem_bus", 32'({mem_addr, mem_wdata}), 32'd0);
    chk("reset_sp", 32'(sp_out), 32'h0000FF00);
    chk("reset_empty", 32'(stack_empty), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    // Word push then word pop round trip
    txn(0, 0, 1, 16'h1234, 0, 16'h0, 0, 3);
    chk("t1_mem_feff", 32'(mem[16'hFEFF]), 32'h12);
    chk("t1_mem_fefe", 32'(mem[16'hFEFE]), 32'h34);
    chk("t1_sp", 32'(sp_out), 32'hFEFE);
    chk("t1_not_empty", 32'(stack_empty), 32'd0);
    re_log.delete();
    txn(0, 1, 1, 16'h0, 0, 16'h1234, 1, 4);
    chk("t2_re_count", 32'(re_log.size()), 32'd2);
    chk("t2_re_addr0", 32'(re_log.size() > 0 ? re_log[0] : 16'h0), 32'hFEFE);
    chk("t2_re_addr1", 32'(re_log.size() > 1 ? re_log[1] : 16'h0), 32'hFEFF);
    chk("t2_sp", 32'(sp_out), 32'hFF00);
    chk("t2_empty", 32'(stack_empty), 32'd1);

    // Simultaneous requests: interrupt unit wins, core follows after its done
    drive(1, 0, 0, 16'h77A5);
    drive(0, 1, 0, 16'h0);
    wait_ack(1, 0, 16'h0, 0, 2);
    wait_ack(0, 0, 16'h00A5, 1, 3);
    chk("t3_core_ack_after_irq_done", 32'(last_ack_cyc), 32'(last_done_cyc + 1));
    drain();
    chk("t3_sp", 32'(sp_out), 32'hFF00);
    chk("t3_mem_feff", 32'(mem[16'hFEFF]), 32'hA5);

    // Underflow on empty stack
    re_log.delete();
    txn(0, 1, 0, 16'h0, 1, 16'h0, 0, 1);
    chk("t4_no_read", 32'(re_log.size()), 32'd0);
    chk("t4_sp", 32'(sp_out), 32'hFF00);
    chk("t4_rdata_held", 32'(rdata), 32'h00A5);

    // Reset in the middle of a word push, during the low-byte write
    drive(0, 0, 1, 16'hBE11);
    wait_ack(0, 0, 16'h0, 0, 3);
    @(posedge clk);
    #1;
    chk("t6_in_wr_lo_we", 32'(mem_we), 32'd1);
    chk("t6_in_wr_lo_addr", 32'(mem_addr), 32'hFEFE);
    reset = 1'b1;
    #1;
    chk("t6_we_dropped", 32'(mem_we), 32'd0);
    chk("t6_sp_reset", 32'(sp_out), 32'hFF00);
    chk("t6_empty", 32'(stack_empty), 32'd1);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("t6_partial_hi", 32'(mem[16'hFEFF]), 32'hBE);
    chk("t6_lo_untouched", 32'(mem[16'hFEFE]), 32'h34);
    @(negedge clk);
    txn(0, 0, 0, 16'hFF5A, 0, 16'h0, 0, 2);
    chk("t6_push_sp", 32'(sp_out), 32'hFEFF);
    txn(0, 1, 1, 16'h0, 1, 16'h0, 0, 1);
    chk("t6_underflow_sp", 32'(sp_out), 32'hFEFF);
    txn(0, 1, 0, 16'h0, 0, 16'h005A, 1, 3);
    chk("t6_pop_sp", 32'(sp_out), 32'hFF00);

    // Fill to SP = FE01 and probe the overflow boundary
    for (int i = 0; i < 127; i++) txn(0, 0, 1, 16'(i * 3 + 16'h0100), 0, 16'h0, 0, 3);
    txn(0, 0, 0, 16'h0077, 0, 16'h0, 0, 2);
    chk("t5_sp_fe01", 32'(sp_out), 32'hFE01);
    we_log.delete();
    txn(1, 0, 1, 16'hABCD, 1, 16'h0, 0, 1);
    chk("t5_no_write", 32'(we_log.size()), 32'd0);
    chk("t5_sp_kept", 32'(sp_out), 32'hFE01);
    txn(1, 0, 0, 16'h00C3, 0, 16'h0, 0, 2);
    chk("t5_mem_fe00", 32'(mem[16'hFE00]), 32'hC3);
    chk("t5_sp_limit", 32'(sp_out), 32'hFE00);
    txn(0, 0, 0, 16'h0011, 1, 16'h0, 0, 1);
    chk("t5_full_sp", 32'(sp_out), 32'hFE00);
    txn(0, 1, 1, 16'h0, 0, 16'h77C3, 1, 4);
    chk("t5_pop_sp", 32'(sp_out), 32'hFE02);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
